// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared FSM state, mode and range constants for the ALU formatter blocks
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONEHOT   = 1'b0;
  localparam logic MODE_LEADONES = 1'b1;

  // Largest encodable value: one-hot tops out at the MSB index, leading ones can fill every bit.
  function automatic int unsigned max_val(input logic mode, input int unsigned len);
    return (mode == MODE_LEADONES) ? 2 * len : 2 * len - 1;
  endfunction

endpackage

// File: rtl/oh_shift_unit.sv
// rtl/oh_shift_unit.sv - result vector register with per-mode init and shift (ENCODER_FAST_EN: one-step full load)
module oh_shift_unit
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
`ifdef ENCODER_FAST_EN
  input  logic [$clog2(N):0] amount,
`else
  input  logic         step,
`endif
  input  logic         mode,
  output logic [N-1:0] vec
);

`ifdef ENCODER_FAST_EN
  logic [N-1:0] full_vec;

  always_comb begin
    full_vec = '0;
    if (mode == MODE_LEADONES) full_vec = ~({N{1'b1}} >> amount);
    else                       full_vec = N'(1) << amount;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       vec <= '0;
    else if (init) vec <= full_vec;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
    end else if (init) begin
      vec <= (mode == MODE_LEADONES) ? '0 : N'(1);
    end else if (step) begin
      // Leading ones grow downward from the MSB; one-hot walks up from bit 0.
      if (mode == MODE_LEADONES) vec <= {1'b1, vec[N-1:1]};
      else                       vec <= {vec[N-2:0], 1'b0};
    end
  end
`endif

endmodule

// File: rtl/u2_to_onehot_encoder.sv
// rtl/u2_to_onehot_encoder.sv - value to one-hot / leading-ones encoder FSM (ENCODER_FAST_EN selects one-cycle build)
module u2_to_onehot_encoder
  import alu_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN-1:0]   o_a_oh,
  output logic [LEN-1:0]   o_b_oh,
  output logic             o_overflow,
  output logic             o_err
);

  localparam int N = 2 * LEN;

  state_t         state, next_state;
  logic           mode_q;
  logic           ovf_q;
  logic           accept;
  logic           in_range;
  logic           run_end;
  logic [N-1:0]   vec;
  logic [N-1:0]   result;

  assign accept   = (state == ST_IDLE) && i_start;
  assign in_range = 32'(i_val) <= max_val(i_mode, LEN);
  assign o_busy   = (state != ST_IDLE);
  assign result   = ovf_q ? '0 : vec;

`ifdef ENCODER_FAST_EN
  assign run_end = 1'b1;

  oh_shift_unit #(.N(N)) u_shift (
    .clk    (i_clk),
    .rst    (i_rst),
    .init   (accept),
    .amount (i_val[$clog2(N):0]),
    .mode   (accept ? i_mode : mode_q),
    .vec    (vec)
  );
`else
  logic [WIDTH-1:0] count;

  // Out-of-range requests finish straight away without touching the vector.
  assign run_end = ovf_q || (count == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                         count <= '0;
    else if (accept)                   count <= i_val;
    else if (state == ST_RUN && !run_end) count <= count - 1'b1;
  end

  oh_shift_unit #(.N(N)) u_shift (
    .clk  (i_clk),
    .rst  (i_rst),
    .init (accept),
    .step (state == ST_RUN && !run_end),
    .mode (accept ? i_mode : mode_q),
    .vec  (vec)
  );
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (i_start) next_state = ST_RUN;
      ST_RUN:  if (run_end) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_ONEHOT;
      ovf_q      <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_a_oh     <= '0;
      o_b_oh     <= '0;
      o_overflow <= 1'b0;
    end else begin
      state  <= next_state;
      o_done <= (state == ST_RUN) && run_end;
      o_err  <= i_start && (state != ST_IDLE);
      if (accept) begin
        mode_q <= i_mode;
        ovf_q  <= ~in_range;
      end
      if (state == ST_RUN && run_end) begin
        o_a_oh     <= result[LEN-1:0];
        o_b_oh     <= result[N-1:LEN];
        o_overflow <= ovf_q;
      end
    end
  end

endmodule
